// File: rtl/data_sram_ctrl_pkg.sv
// Shared types and defaults for the CPU data-memory to async-SRAM controller.
package data_sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    WHOLD = 3'd3,
    DONE  = 3'd4
  } sram_state_t;

  localparam int SRAM_ADDR_W     = 20;
  localparam int SRAM_READ_WAIT  = 2;
  localparam int SRAM_WRITE_WAIT = 2;
  localparam int SRAM_CNT_W      = 8;

  // The wait counter counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [SRAM_CNT_W-1:0] wait_load(input int unsigned waits);
    return SRAM_CNT_W'(waits - 32'd1);
  endfunction

endpackage

// File: rtl/data_sram_ctrl_if.sv
// CPU mem-stage data port as seen by the SRAM controller (names relative to the controller).
interface data_sram_ctrl_if;

  logic [31:0] ram_addr_i;
  logic [31:0] ram_data_i;
  logic        ram_re_i;
  logic        ram_we_i;
  logic [3:0]  ram_mask_i;
  logic [31:0] ram_data_o;
  logic        stallreq_o;

  modport master (
    output ram_addr_i, ram_data_i, ram_re_i, ram_we_i, ram_mask_i,
    input  ram_data_o, stallreq_o
  );

  modport slave (
    input  ram_addr_i, ram_data_i, ram_re_i, ram_we_i, ram_mask_i,
    output ram_data_o, stallreq_o
  );

endinterface

// File: rtl/data_sram_ctrl.sv
// Turns single-cycle CPU data requests into multi-cycle async-SRAM transactions,
// stalling the pipeline until the access has completed.
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int READ_WAIT  = SRAM_READ_WAIT,
  parameter int WRITE_WAIT = SRAM_WRITE_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  data_sram_ctrl_if.slave   cpu,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [31:0]       sram_data_i,
  output logic [31:0]       sram_data_o,
  output logic              sram_data_oe_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic [3:0]        sram_be_n_o
);

  sram_state_t             r_state;
  logic [SRAM_CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]       r_addr;
  logic [31:0]             r_wdata;
  logic [31:0]             r_rdata;
  logic                    r_data_oe;
  logic                    r_ce_n;
  logic                    r_oe_n;
  logic                    r_we_n;
  logic [3:0]              r_be_n;

  sram_state_t             w_state_nxt;
  logic [SRAM_CNT_W-1:0]   w_cnt_nxt;
  logic [ADDR_W-1:0]       w_addr_nxt;
  logic [31:0]             w_wdata_nxt;
  logic [31:0]             w_rdata_nxt;
  logic                    w_data_oe_nxt;
  logic                    w_ce_n_nxt;
  logic                    w_oe_n_nxt;
  logic                    w_we_n_nxt;
  logic [3:0]              w_be_n_nxt;
  logic                    w_unused_addr;

  // Byte offset and address bits above the SRAM window are not decoded here.
  assign w_unused_addr = ^{cpu.ram_addr_i[1:0], cpu.ram_addr_i[31:ADDR_W+2]};

  // Next state and next values of all registered SRAM-side outputs.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_rdata_nxt   = r_rdata;
    w_data_oe_nxt = r_data_oe;
    w_ce_n_nxt    = r_ce_n;
    w_oe_n_nxt    = r_oe_n;
    w_we_n_nxt    = r_we_n;
    w_be_n_nxt    = r_be_n;
    case (r_state)
      IDLE: begin
        if (cpu.ram_we_i) begin
          w_addr_nxt    = cpu.ram_addr_i[ADDR_W+1:2];
          w_wdata_nxt   = cpu.ram_data_i;
          w_be_n_nxt    = ~cpu.ram_mask_i;
          w_ce_n_nxt    = 1'b0;
          w_we_n_nxt    = 1'b0;
          w_data_oe_nxt = 1'b1;
          w_cnt_nxt     = wait_load(WRITE_WAIT);
          w_state_nxt   = WRITE;
        end else if (cpu.ram_re_i) begin
          w_addr_nxt    = cpu.ram_addr_i[ADDR_W+1:2];
          w_be_n_nxt    = 4'h0;
          w_ce_n_nxt    = 1'b0;
          w_oe_n_nxt    = 1'b0;
          w_cnt_nxt     = wait_load(READ_WAIT);
          w_state_nxt   = READ;
        end else begin
          w_state_nxt   = IDLE;
        end
      end
      READ: begin
        if (r_cnt == {SRAM_CNT_W{1'b0}}) begin
          w_rdata_nxt = sram_data_i;
          w_ce_n_nxt  = 1'b1;
          w_oe_n_nxt  = 1'b1;
          w_be_n_nxt  = 4'hF;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt   = r_cnt - SRAM_CNT_W'(1);
        end
      end
      WRITE: begin
        if (r_cnt == {SRAM_CNT_W{1'b0}}) begin
          w_we_n_nxt  = 1'b1;
          w_state_nxt = WHOLD;
        end else begin
          w_cnt_nxt   = r_cnt - SRAM_CNT_W'(1);
        end
      end
      WHOLD: begin
        // Data and address stay driven one cycle past we_n rising for hold time.
        w_ce_n_nxt    = 1'b1;
        w_data_oe_nxt = 1'b0;
        w_be_n_nxt    = 4'hF;
        w_state_nxt   = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_ce_n_nxt    = 1'b1;
        w_oe_n_nxt    = 1'b1;
        w_we_n_nxt    = 1'b1;
        w_be_n_nxt    = 4'hF;
        w_data_oe_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
    endcase
  end

  // State, counter and output registers; reset drops every strobe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= {SRAM_CNT_W{1'b0}};
      r_addr    <= {ADDR_W{1'b0}};
      r_wdata   <= 32'h0;
      r_rdata   <= 32'h0;
      r_data_oe <= 1'b0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_be_n    <= 4'hF;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rdata   <= w_rdata_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_ce_n    <= w_ce_n_nxt;
      r_oe_n    <= w_oe_n_nxt;
      r_we_n    <= w_we_n_nxt;
      r_be_n    <= w_be_n_nxt;
    end
  end

  // The stall must rise in the same cycle the request appears, so it is combinational.
  assign cpu.stallreq_o = !rst &&
                          (((r_state == IDLE) && (cpu.ram_re_i || cpu.ram_we_i)) ||
                           (r_state inside {READ, WRITE, WHOLD}));
  assign cpu.ram_data_o = r_rdata;

  assign sram_addr_o    = r_addr;
  assign sram_data_o    = r_wdata;
  assign sram_data_oe_o = r_data_oe;
  assign sram_ce_n_o    = r_ce_n;
  assign sram_oe_n_o    = r_oe_n;
  assign sram_we_n_o    = r_we_n;
  assign sram_be_n_o    = r_be_n;

endmodule
